// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter slice.
//   arb_state_e : sequencer states (IDLE=0, ACCESS=1, RESP=2)
//   owner_e     : requester identity (OWN_IF=0, OWN_LS=1)
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   req[1:0]     in  : bit 0 = IF request, bit 1 = LS request
//   last_owner   in  : requester granted most recently
//   grant_valid  out : at least one request present
//   grant_owner  out : selected requester (meaningful when grant_valid)
module mem_arb_rr
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic       grant_valid,
  output owner_e     grant_owner
);

  always_comb begin
    grant_valid = |req;
    grant_owner = OWN_IF;
    unique case (req)
      2'b01:   grant_owner = OWN_IF;
      2'b10:   grant_owner = OWN_LS;
      // Contention: the requester that did not win last time goes next.
      2'b11:   grant_owner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
      default: grant_owner = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer sharing one single-port 16-bit Memory between
// instruction fetch (IF, read-only) and load/store (LS, read/write).
// Each access runs arbitrate/latch -> ACCESS -> RESP; a new request may be
// selected in RESP, giving one access every two cycles at best.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             IF read request (held until if_gnt)
//   if_gnt/if_rvalid           one-cycle pulses: latched / data valid
//   if_rdata/if_err            read data, misalignment flag (with rvalid)
//   ls_req/ls_we/ls_addr/ls_wdata  LS request (held until ls_gnt)
//   ls_gnt/ls_rvalid           one-cycle pulses: latched / data or write done
//   ls_rdata/ls_err            read data, misalignment flag (with rvalid)
//   mem_addr/mem_we/mem_din    to Memory (byte address, Memory shifts >>1)
//   mem_dout                   from Memory (asynchronous read)
//   busy                       high while in ACCESS
//
// Build option:
//   MEM_ARB_ALIGN_CHK_EN  when defined, an odd latched address flags err
//                         for the owner and suppresses the write.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic   sel_valid;
  owner_e sel_owner;
  logic   misalign;

  mem_arb_rr u_rr (
    .req         ({ls_req, if_req}),
    .last_owner  (last_owner_q),
    .grant_valid (sel_valid),
    .grant_owner (sel_owner)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (sel_valid) begin
          state_d      = ACCESS;
          last_owner_d = sel_owner;
          owner_d      = sel_owner;
          if (sel_owner == OWN_LS) begin
            addr_d  = ls_addr;
            we_d    = ls_we;
            wdata_d = ls_wdata;
          end else begin
            addr_d = if_addr;
            we_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        // Memory reads asynchronously, so on a write this is the old word.
        rdata_d = mem_dout;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_IF;
      owner_q      <= OWN_IF;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign misalign = addr_q[0];
`else
  assign misalign = 1'b0;
`endif

  // mem_we derives from state_q, so asserting reset aborts a write at once.
  assign busy      = (state_q == ACCESS);
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign mem_we    = busy && we_q && !misalign;

  assign if_gnt    = busy && (owner_q == OWN_IF);
  assign ls_gnt    = busy && (owner_q == OWN_LS);
  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign ls_rvalid = (state_q == RESP) && (owner_q == OWN_LS);
  assign if_rdata  = rdata_q;
  assign ls_rdata  = rdata_q;
  assign if_err    = if_rvalid && misalign;
  assign ls_err    = ls_rvalid && misalign;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural 1K-word memory.
// Honours MEM_ARB_ALIGN_CHK_EN to select the misaligned-access expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [15:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [15:0] ls_rdata;
  logic [15:0] mem_addr, mem_din, mem_dout;
  logic        mem_we, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy)
  );

  // Memory: 1K words, synchronous write, asynchronous read, word = addr >> 1.
  logic [15:0] mem [0:1023];
  always @(posedge clk) if (mem_we) mem[mem_addr[10:1]] <= mem_din;
  assign mem_dout = mem[mem_addr[10:1]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete access with fixed timing: req in N, gnt in N+1, rvalid in N+2.
  task automatic do_xact(input string name, input logic is_ls, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic chk_rd, input logic [15:0] exp_rd,
                         input logic exp_err);
    @(posedge clk); #1;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(negedge clk);
    check({name, ".gntN"}, {30'd0, if_gnt, ls_gnt}, 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0;
    ls_req = 1'b0;
    @(negedge clk);
    check({name, ".gnt"}, {30'd0, ls_gnt, if_gnt}, is_ls ? 32'd2 : 32'd1);
    check({name, ".busy"}, {31'd0, busy}, 32'd1);
    check({name, ".we"}, {31'd0, mem_we}, {31'd0, we & ~exp_err});
    check({name, ".maddr"}, {16'd0, mem_addr}, {16'd0, addr});
    if (we) check({name, ".mdin"}, {16'd0, mem_din}, {16'd0, wdata});
    @(posedge clk); #1;
    @(negedge clk);
    check({name, ".rvalid"}, {30'd0, ls_rvalid, if_rvalid}, is_ls ? 32'd2 : 32'd1);
    check({name, ".weRsp"}, {30'd0, busy, mem_we}, 32'd0);
    check({name, ".err"}, {30'd0, ls_err, if_err},
          exp_err ? (is_ls ? 32'd2 : 32'd1) : 32'd0);
    if (chk_rd)
      check({name, ".rdata"}, {16'd0, is_ls ? ls_rdata : if_rdata}, {16'd0, exp_rd});
  endtask

  typedef struct {
    string       name;
    logic        is_ls;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"wrBEEF",   1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{"ifRd10",   1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF};
    vecs[2] = '{"wr1234",   1'b1, 1'b1, 16'h0012, 16'h1234, 1'b0, 16'h0000};
    vecs[3] = '{"lsRd12",   1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'h1234};
    vecs[4] = '{"wrCAFEold",1'b1, 1'b1, 16'h0010, 16'hCAFE, 1'b1, 16'hBEEF};
    vecs[5] = '{"ifRdCAFE", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hCAFE};
    vecs[6] = '{"ifRd12",   1'b0, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'h1234};
    vecs[7] = '{"wrTop",    1'b1, 1'b1, 16'h07FE, 16'h00FF, 1'b0, 16'h0000};
    vecs[8] = '{"rdTop",    1'b1, 1'b0, 16'h07FE, 16'h0000, 1'b1, 16'h00FF};

    // Reset state
    #3;
    check("rst.outs", {26'd0, if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err}, 32'd0);
    check("rst.mem", {14'd0, busy, mem_we, mem_addr}, 32'd0);
    check("rst.din", {16'd0, mem_din}, 32'd0);
    do_reset();

    foreach (vecs[i])
      do_xact(vecs[i].name, vecs[i].is_ls, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].chk_rd, vecs[i].exp_rd, 1'b0);

    // Both requesting from reset: LS, IF, LS, IF; one grant every two cycles.
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0010;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0012;
    @(negedge clk);
    check("rr.c0", {30'd0, ls_gnt, if_gnt}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("rr.gnt%0d", k), {30'd0, ls_gnt, if_gnt},
            (k == 1 || k == 5) ? 32'd2 : (k == 3 || k == 7) ? 32'd1 : 32'd0);
      check($sformatf("rr.rv%0d", k), {30'd0, ls_rvalid, if_rvalid},
            (k == 2 || k == 6) ? 32'd2 : (k == 4 || k == 8) ? 32'd1 : 32'd0);
      if (k == 2) check("rr.lsdata", {16'd0, ls_rdata}, 32'h1234);
      if (k == 4) check("rr.ifdata", {16'd0, if_rdata}, 32'hCAFE);
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (4) @(posedge clk);

    // Reset during the ACCESS cycle of a write aborts it.
    do_xact("wr7777", 1'b1, 1'b1, 16'h0020, 16'h7777, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 16'h1234;
    @(posedge clk); #1;
    ls_req = 1'b0;
    #1;
    check("abort.weBefore", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.weNow", {29'd0, mem_we, busy, ls_gnt}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_xact("abort.rd", 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h7777, 1'b0);

`ifdef MEM_ARB_ALIGN_CHK_EN
    do_xact("misalign", 1'b1, 1'b1, 16'h0011, 16'h5555, 1'b1, 16'hCAFE, 1'b1);
    do_xact("misalign.rd", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hCAFE, 1'b0);
`else
    // addr[0] ignored: 0x0011 writes the word at 0x0010.
    do_xact("odd.wr", 1'b1, 1'b1, 16'h0011, 16'h5555, 1'b1, 16'hCAFE, 1'b0);
    do_xact("odd.rd", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h5555, 1'b0);
    do_xact("restore", 1'b1, 1'b1, 16'h0010, 16'hCAFE, 1'b1, 16'h5555, 1'b0);
`endif

    // Lone IF request: one gnt, one rvalid, busy exactly one cycle, LS silent.
    begin
      int busy_cnt = 0, gnt_cyc = -1, rv_cyc = -1, ls_any = 0;
      logic [15:0] got = '0;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 16'h0010;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        busy_cnt += int'(busy);
        if (if_gnt) gnt_cyc = k;
        if (if_rvalid) begin rv_cyc = k; got = if_rdata; end
        ls_any += int'(ls_gnt | ls_rvalid);
        if (k == 1) if_req = 1'b0;
      end
      check("solo.busyCnt", busy_cnt, 32'd1);
      check("solo.gntCyc", gnt_cyc, 32'd1);
      check("solo.rvCyc", rv_cyc, 32'd2);
      check("solo.rdata", {16'd0, got}, 32'hCAFE);
      check("solo.lsQuiet", ls_any, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
